hp_drain_animator: RTL and testbench

- Sits between the battle datapath HP outputs (player or AI HP) and the two-digit decimal HEX display decoder.
- The display counts the HP down (or up, on heal) one point per animation tick instead of jumping to the new value.
- It reports busy/done so the battle control FSM can hold off the next turn until the animation finishes.
- It drives a low-HP warning LED (steady at 0 HP, blinking when low).
- One instance per combatant.

---
 rtl/hp_drain_animator_if.sv | 22 ++
 rtl/hp_drain_animator.sv | 99 +++++++++
 tb/tb_hp_drain_animator.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/hp_drain_animator_if.sv
// Handshake bundle between the battle datapath and one HP display animator.
// The master side supplies the live HP and the load strobe; the animator (slave) returns the display state.
interface hp_drain_animator_if #(
  parameter int HP_W = 4
);
  logic [HP_W-1:0] target_hp;
  logic            load;
  logic [HP_W-1:0] disp_hp;
  logic            busy;
  logic            done;
  logic            low_blink;

  modport master (
    output target_hp, load,
    input  disp_hp, busy, done, low_blink
  );

  modport slave (
    input  target_hp, load,
    output disp_hp, busy, done, low_blink
  );
endinterface

// File: rtl/hp_drain_animator.sv
// Steps a displayed HP value toward the live HP one point per tick, reporting busy/done,
// and drives a low-HP warning LED (steady at zero, blinking inside the low band).
module hp_drain_animator #(
  parameter int HP_W       = 4,
  parameter int TICK_DIV   = 25000000,
  parameter int CNT_W      = 25,
  parameter int LOW_THRESH = 3
) (
  input  logic               clk,
  input  logic               rst,
  hp_drain_animator_if.slave bus
);
  typedef enum logic {IDLE, STEP} state_t;

  state_t           state;
  logic [CNT_W-1:0] step_cnt;
  logic [CNT_W-1:0] blink_cnt;
  logic [HP_W-1:0]  disp_hp;
  logic [HP_W-1:0]  next_hp;
  logic             busy;
  logic             done;
  logic             low_blink;
  logic             tick_end;
  logic             blink_wrap;
  logic             in_low_band;

  assign bus.disp_hp   = disp_hp;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.low_blink = low_blink;

  assign tick_end    = (step_cnt == CNT_W'(TICK_DIV - 1));
  assign blink_wrap  = (blink_cnt == CNT_W'(TICK_DIV - 1));
  assign in_low_band = (disp_hp != '0) && (disp_hp <= HP_W'(LOW_THRESH));
  // Only ever used when target differs from the display, so it never wraps.
  assign next_hp     = (bus.target_hp > disp_hp) ? disp_hp + HP_W'(1) : disp_hp - HP_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      step_cnt <= '0;
      disp_hp  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.load) begin
            disp_hp <= bus.target_hp;
          end else if (bus.target_hp != disp_hp) begin
            state    <= STEP;
            busy     <= 1'b1;
            step_cnt <= '0;
          end
        end
        STEP: begin
          if (bus.load) begin
            disp_hp <= bus.target_hp;
            busy    <= 1'b0;
            state   <= IDLE;
          end else if (bus.target_hp == disp_hp) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end else if (tick_end) begin
            step_cnt <= '0;
            disp_hp  <= next_hp;
            if (next_hp == bus.target_hp) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end
          end else begin
            step_cnt <= step_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Blink timebase runs regardless of animation state so the LED rhythm stays even.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt <= '0;
      low_blink <= 1'b0;
    end else begin
      blink_cnt <= blink_wrap ? '0 : blink_cnt + CNT_W'(1);
      if (disp_hp == '0) begin
        low_blink <= 1'b1;
      end else if (in_low_band) begin
        if (blink_wrap) low_blink <= ~low_blink;
      end else begin
        low_blink <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_hp_drain_animator.sv
// Directed and randomized check of hp_drain_animator against a time-based reference model.
module tb_hp_drain_animator;
  localparam int HP_W = 4;
  localparam int TD   = 4;
  localparam int LOW  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;

  // Reference model: animation age counts cycles since the animation started.
  int m_disp, anim_age, blink_age;
  bit m_busy, m_done, m_blink;

  hp_drain_animator_if #(.HP_W(HP_W)) bus ();

  hp_drain_animator #(.HP_W(HP_W), .TICK_DIV(TD), .CNT_W(3), .LOW_THRESH(LOW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_disp = 0; m_busy = 0; m_done = 0; m_blink = 0; anim_age = 0; blink_age = 0;
  endtask

  task automatic model_edge();
    int tgt;
    bit wrap;
    tgt  = int'(bus.target_hp);
    wrap = (blink_age == TD - 1);
    blink_age = (blink_age + 1) % TD;
    if (m_disp == 0)        m_blink = 1;
    else if (m_disp <= LOW) m_blink = wrap ? ~m_blink : m_blink;
    else                    m_blink = 0;
    m_done = 0;
    if (bus.load) begin
      m_disp = tgt;
      m_busy = 0;
    end else if (!m_busy) begin
      if (tgt != m_disp) begin
        m_busy   = 1;
        anim_age = 0;
      end
    end else if (tgt == m_disp) begin
      m_busy = 0;
      m_done = 1;
    end else begin
      anim_age++;
      if (anim_age % TD == 0) begin
        m_disp += (tgt > m_disp) ? 1 : -1;
        if (m_disp == tgt) begin
          m_busy = 0;
          m_done = 1;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".disp"},  8'(bus.disp_hp),  8'(m_disp));
    chk({tag, ".busy"},  8'(bus.busy),     8'(m_busy));
    chk({tag, ".done"},  8'(bus.done),     8'(m_done));
    chk({tag, ".blink"}, 8'(bus.low_blink), 8'(m_blink));
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag);
  endtask

  task automatic run_until_disp(input string tag, input int value, input int budget);
    int k;
    k = 0;
    while (m_disp != value && k < budget) begin
      cycle(tag);
      k++;
    end
    chk({tag, ".reached"}, 8'(m_disp), 8'(value));
  endtask

  task automatic do_load(input string tag, input int value);
    bus.target_hp = HP_W'(value);
    bus.load      = 1'b1;
    cycle(tag);
    bus.load      = 1'b0;
  endtask

  initial begin
    bus.target_hp = '0;
    bus.load      = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    rst = 1'b0;
    run("post_reset", 3);

    do_load("load12", 12);
    chk("load12.value", 8'(bus.disp_hp), 8'd12);
    run("load12.hold", 3);

    bus.target_hp = 4'd9;
    run("drain9", 16);
    chk("drain9.final", 8'(bus.disp_hp), 8'd9);

    bus.target_hp = 4'd5;
    run_until_disp("toward5", 8, 40);
    bus.target_hp = 4'd11;
    run_until_disp("reverse11", 11, 60);
    run("reverse11.tail", 3);

    bus.target_hp = 4'd4;
    run_until_disp("toward4", 10, 40);
    do_load("load_mid", 4);
    chk("load_mid.value", 8'(bus.disp_hp), 8'd4);
    run("load_mid.tail", 3);

    do_load("low2", 2);
    run("blink2", 20);
    do_load("zero", 0);
    run("steady0", 10);
    do_load("five", 5);
    run("off5", 10);
    do_load("three", 3);
    run("enter_low", 10);

    bus.target_hp = 4'd12;
    run("pre_abort", 6);
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    #2;
    rst = 1'b0;
    run("after_abort", 4);

    for (int i = 0; i < 600; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3) begin
        bus.target_hp = HP_W'($urandom_range(0, 15));
        bus.load      = 1'b1;
      end else if (r < 12) begin
        bus.target_hp = HP_W'($urandom_range(0, 15));
        bus.load      = 1'b0;
      end else begin
        bus.load = 1'b0;
      end
      cycle("rand");
    end
    bus.load = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
